// File: rtl/pipeline_controller_if.sv
// Handshake/control bundle between the pipeline controller and its surroundings.
//   start, instr, instr_valid, load_use_hazard, branch_mispredict : into the controller
//   ex_ctrl, m_ctrl, wb_ctrl                                      : per-stage control words
//   if_flush, id_flush, ex_flush, pc_stall, ifid_stall            : pipeline register steering
//   illegal, busy, done, cycle_count                              : status
interface pipeline_controller_if #(
  parameter int unsigned INST_W = 32,
  parameter int unsigned CNT_W  = 16
);
  logic              start;
  logic [INST_W-1:0] instr;
  logic              instr_valid;
  logic              load_use_hazard;
  logic              branch_mispredict;

  logic [3:0]        ex_ctrl;
  logic [2:0]        m_ctrl;
  logic [1:0]        wb_ctrl;
  logic              if_flush;
  logic              id_flush;
  logic              ex_flush;
  logic              pc_stall;
  logic              ifid_stall;
  logic              illegal;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  cycle_count;

  // Side that drives instructions and hazard information
  modport master (
    output start, instr, instr_valid, load_use_hazard, branch_mispredict,
    input  ex_ctrl, m_ctrl, wb_ctrl, if_flush, id_flush, ex_flush,
           pc_stall, ifid_stall, illegal, busy, done, cycle_count
  );

  // Controller side
  modport slave (
    input  start, instr, instr_valid, load_use_hazard, branch_mispredict,
    output ex_ctrl, m_ctrl, wb_ctrl, if_flush, id_flush, ex_flush,
           pc_stall, ifid_stall, illegal, busy, done, cycle_count
  );
endinterface

// File: rtl/pipeline_controller.sv
// Main control unit of an in-order pipeline: decodes the ID-stage opcode into
// EX/MEM/WB control words, steers stalls and flushes for load-use hazards and
// branch mispredicts, and sequences halt/drain.
//   clk         : clock, rising edge
//   rst         : asynchronous active-high reset
//   ctrl_if     : slave side of pipeline_controller_if (inputs, controls, status)
// State, drain counter and cycle counter are registered; all other outputs are
// combinational from the current state and inputs.
module pipeline_controller #(
  parameter int unsigned INST_W = 32,
  parameter int unsigned OP_LSB = 26,
  parameter int unsigned OP_W   = 6,
  parameter int unsigned STAGES = 5,
  parameter int unsigned CNT_W  = 16,
  parameter logic [OP_W-1:0] OP_RTYPE = OP_W'(0),
  parameter logic [OP_W-1:0] OP_LW    = OP_W'(35),
  parameter logic [OP_W-1:0] OP_SW    = OP_W'(43),
  parameter logic [OP_W-1:0] OP_BEQ   = OP_W'(4),
  parameter logic [OP_W-1:0] OP_JMP   = OP_W'(2),
  parameter logic [OP_W-1:0] OP_NOP   = OP_W'(62),
  parameter logic [OP_W-1:0] OP_HLT   = OP_W'(63)
) (
  input logic                  clk,
  input logic                  rst,
  pipeline_controller_if.slave ctrl_if
);

  // Wide enough to hold STAGES-2 for any STAGES >= 2
  localparam int unsigned DRN_W = (STAGES > 2) ? $clog2(STAGES) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e           state_q;
  logic [DRN_W-1:0] drain_q;
  logic [CNT_W-1:0] cnt_q;

  logic [OP_W-1:0]  opcode;
  logic [3:0]       dec_ex;
  logic [2:0]       dec_m;
  logic [1:0]       dec_wb;
  logic             dec_legal;
  logic             hlt_take;
  logic [CNT_W-1:0] cnt_inc;

  assign opcode = ctrl_if.instr[OP_LSB +: OP_W];

  // Opcode decode, independent of state
  always_comb begin
    dec_ex    = 4'b0000;
    dec_m     = 3'b000;
    dec_wb    = 2'b00;
    dec_legal = 1'b1;
    case (opcode)
      OP_RTYPE: begin dec_ex = 4'b1100; dec_wb = 2'b10; end
      OP_LW:    begin dec_ex = 4'b0001; dec_m = 3'b010; dec_wb = 2'b11; end
      OP_SW:    begin dec_ex = 4'b0001; dec_m = 3'b001; end
      OP_BEQ:   begin dec_ex = 4'b0010; dec_m = 3'b100; end
      OP_JMP, OP_NOP, OP_HLT: ;
      default:  dec_legal = 1'b0;
    endcase
  end

  // A halt only counts when it is on the correct path and not being stalled
  assign hlt_take = ctrl_if.instr_valid && !ctrl_if.load_use_hazard &&
                    !ctrl_if.branch_mispredict && (opcode == OP_HLT);

  assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

  // State, drain counter and cycle counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      drain_q <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (ctrl_if.start) begin
            state_q <= S_RUN;
            cnt_q   <= '0;
          end
        end
        S_RUN: begin
          cnt_q <= cnt_inc;
          if (hlt_take) begin
            state_q <= S_DRAIN;
            drain_q <= DRN_W'(STAGES - 2);
          end
        end
        S_DRAIN: begin
          cnt_q <= cnt_inc;
          // A mispredict means the halt was wrong-path: resume execution
          if (ctrl_if.branch_mispredict) begin
            state_q <= S_RUN;
            drain_q <= '0;
          end else if (drain_q == '0) begin
            state_q <= S_DONE;
          end else begin
            drain_q <= drain_q - DRN_W'(1);
          end
        end
        S_DONE: begin
          if (ctrl_if.start) begin
            state_q <= S_RUN;
            cnt_q   <= '0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Control words, stalls and flushes
  always_comb begin
    ctrl_if.ex_ctrl    = 4'b0000;
    ctrl_if.m_ctrl     = 3'b000;
    ctrl_if.wb_ctrl    = 2'b00;
    ctrl_if.if_flush   = 1'b0;
    ctrl_if.id_flush   = 1'b0;
    ctrl_if.ex_flush   = 1'b0;
    ctrl_if.pc_stall   = 1'b0;
    ctrl_if.ifid_stall = 1'b0;
    ctrl_if.illegal    = 1'b0;
    ctrl_if.busy       = 1'b0;
    ctrl_if.done       = 1'b0;
    case (state_q)
      S_RUN: begin
        ctrl_if.busy = 1'b1;
        if (ctrl_if.branch_mispredict) begin
          ctrl_if.if_flush = 1'b1;
          ctrl_if.id_flush = 1'b1;
        end else if (ctrl_if.load_use_hazard) begin
          // Hold IF/PC and inject a bubble into EX
          ctrl_if.pc_stall   = 1'b1;
          ctrl_if.ifid_stall = 1'b1;
          ctrl_if.id_flush   = 1'b1;
        end else if (ctrl_if.instr_valid) begin
          if (dec_legal) begin
            ctrl_if.ex_ctrl = dec_ex;
            ctrl_if.m_ctrl  = dec_m;
            ctrl_if.wb_ctrl = dec_wb;
          end else begin
            ctrl_if.illegal = 1'b1;
          end
        end
      end
      S_DRAIN: begin
        ctrl_if.busy = 1'b1;
        if (ctrl_if.branch_mispredict) begin
          // PC must be free to take the redirect target
          ctrl_if.if_flush = 1'b1;
          ctrl_if.id_flush = 1'b1;
        end else begin
          ctrl_if.pc_stall = 1'b1;
          ctrl_if.if_flush = 1'b1;
        end
      end
      S_DONE:  ctrl_if.done = 1'b1;
      default: ;
    endcase
  end

  assign ctrl_if.cycle_count = cnt_q;

endmodule

// File: tb/tb_pipeline_controller.sv
// Scoreboard bench for pipeline_controller: each driven cycle pushes its
// expected outputs, which are popped and compared once the outputs settle.
// A second instance with CNT_W=2 exercises cycle counter saturation.
module tb_pipeline_controller;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_JMP   = 6'd2;
  localparam logic [5:0] OP_NOP   = 6'd62;
  localparam logic [5:0] OP_HLT   = 6'd63;
  localparam logic [5:0] OP_BAD   = 6'd17;

  // Control words {ex[3:0], m[2:0], wb[1:0]}
  localparam logic [8:0] C_ZERO  = 9'b0000_000_00;
  localparam logic [8:0] C_RTYPE = 9'b1100_000_10;
  localparam logic [8:0] C_LW    = 9'b0001_010_11;
  localparam logic [8:0] C_SW    = 9'b0001_001_00;
  localparam logic [8:0] C_BEQ   = 9'b0010_100_00;

  // Flags {if_flush, id_flush, ex_flush, pc_stall, ifid_stall, illegal, busy, done}
  localparam logic [7:0] F_ZERO = 8'b0000_0000;
  localparam logic [7:0] F_RUN  = 8'b0000_0010;
  localparam logic [7:0] F_HAZ  = 8'b0101_1010;
  localparam logic [7:0] F_MIS  = 8'b1100_0010;
  localparam logic [7:0] F_DRN  = 8'b1001_0010;
  localparam logic [7:0] F_ILL  = 8'b0000_0110;
  localparam logic [7:0] F_DONE = 8'b0000_0001;

  typedef struct packed {
    logic [8:0]  ctl;
    logic [7:0]  flg;
    logic [15:0] cnt;
  } exp_t;

  logic clk;
  logic rst;

  pipeline_controller_if #(.INST_W(32), .CNT_W(16)) if0 ();
  pipeline_controller_if #(.INST_W(32), .CNT_W(2))  if1 ();

  pipeline_controller #(.CNT_W(16)) u_dut0 (.clk(clk), .rst(rst), .ctrl_if(if0.slave));
  pipeline_controller #(.CNT_W(2))  u_dut1 (.clk(clk), .rst(rst), .ctrl_if(if1.slave));

  exp_t sb[$];
  int   n_cmp;
  int   n_err;
  int   exp_cnt [2];
  int   cnt_max [2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pop one expectation and compare it against the selected instance
  task automatic compare(input int sel, input string name);
    exp_t        e;
    logic [8:0]  ctl;
    logic [7:0]  flg;
    logic [31:0] cnt;
    if (sb.size() == 0) begin
      check_eq({name, ".sb_empty"}, 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    if (sel == 0) begin
      ctl = {if0.ex_ctrl, if0.m_ctrl, if0.wb_ctrl};
      flg = {if0.if_flush, if0.id_flush, if0.ex_flush, if0.pc_stall,
             if0.ifid_stall, if0.illegal, if0.busy, if0.done};
      cnt = 32'(if0.cycle_count);
    end else begin
      ctl = {if1.ex_ctrl, if1.m_ctrl, if1.wb_ctrl};
      flg = {if1.if_flush, if1.id_flush, if1.ex_flush, if1.pc_stall,
             if1.ifid_stall, if1.illegal, if1.busy, if1.done};
      cnt = 32'(if1.cycle_count);
    end
    check_eq({name, ".ctl"}, 32'(ctl), 32'(e.ctl));
    check_eq({name, ".flags"}, 32'(flg), 32'(e.flg));
    check_eq({name, ".cycle_count"}, cnt, 32'(e.cnt));
  endtask

  // One clock cycle: drive at negedge, check settled outputs, advance the count model
  task automatic step(input int sel, input string name, input logic st, input logic [5:0] op,
                      input logic v, input logic haz, input logic mis,
                      input logic [8:0] ctl, input logic [7:0] flg,
                      input bit active, input bit clr);
    exp_t e;
    @(negedge clk);
    if (sel == 0) begin
      if0.start = st; if0.instr = {op, 26'h0}; if0.instr_valid = v;
      if0.load_use_hazard = haz; if0.branch_mispredict = mis;
    end else begin
      if1.start = st; if1.instr = {op, 26'h0}; if1.instr_valid = v;
      if1.load_use_hazard = haz; if1.branch_mispredict = mis;
    end
    e.ctl = ctl;
    e.flg = flg;
    e.cnt = 16'(exp_cnt[sel]);
    sb.push_back(e);
    #1;
    compare(sel, name);
    if (clr) exp_cnt[sel] = 0;
    else if (active && exp_cnt[sel] < cnt_max[sel]) exp_cnt[sel]++;
  endtask

  task automatic idle_inputs();
    if0.start = 1'b0; if0.instr = '0; if0.instr_valid = 1'b0;
    if0.load_use_hazard = 1'b0; if0.branch_mispredict = 1'b0;
    if1.start = 1'b0; if1.instr = '0; if1.instr_valid = 1'b0;
    if1.load_use_hazard = 1'b0; if1.branch_mispredict = 1'b0;
  endtask

  initial begin
    exp_t e;
    n_cmp = 0;
    n_err = 0;
    exp_cnt[0] = 0; exp_cnt[1] = 0;
    cnt_max[0] = 65535; cnt_max[1] = 3;
    idle_inputs();
    rst = 1'b1;

    #6;
    e = '0; sb.push_back(e); compare(0, "reset");
    @(negedge clk);
    rst = 1'b0;

    // Startup and decode of every opcode class
    step(0, "idle",      0, OP_NOP,   0, 0, 0, C_ZERO,  F_ZERO, 0, 0);
    step(0, "start",     1, OP_LW,    1, 0, 0, C_ZERO,  F_ZERO, 0, 1);
    step(0, "lw",        0, OP_LW,    1, 0, 0, C_LW,    F_RUN,  1, 0);
    step(0, "hazard",    0, OP_RTYPE, 1, 1, 0, C_ZERO,  F_HAZ,  1, 0);
    step(0, "rtype",     0, OP_RTYPE, 1, 0, 0, C_RTYPE, F_RUN,  1, 0);
    step(0, "sw",        0, OP_SW,    1, 0, 0, C_SW,    F_RUN,  1, 0);
    step(0, "beq",       0, OP_BEQ,   1, 0, 0, C_BEQ,   F_RUN,  1, 0);
    step(0, "jmp",       0, OP_JMP,   1, 0, 0, C_ZERO,  F_RUN,  1, 0);
    step(0, "nop",       0, OP_NOP,   1, 0, 0, C_ZERO,  F_RUN,  1, 0);
    step(0, "illegal",   0, OP_BAD,   1, 0, 0, C_ZERO,  F_ILL,  1, 0);
    step(0, "invalid",   0, OP_BAD,   0, 0, 0, C_ZERO,  F_RUN,  1, 0);
    step(0, "start_run", 1, OP_RTYPE, 1, 0, 0, C_RTYPE, F_RUN,  1, 0);
    step(0, "mis_lw",    0, OP_LW,    1, 1, 1, C_ZERO,  F_MIS,  1, 0);

    // Halts that must not be taken
    step(0, "hlt_mis",   0, OP_HLT,   1, 0, 1, C_ZERO,  F_MIS,  1, 0);
    step(0, "hlt_haz",   0, OP_HLT,   1, 1, 0, C_ZERO,  F_HAZ,  1, 0);
    step(0, "post_haz",  0, OP_RTYPE, 1, 0, 0, C_RTYPE, F_RUN,  1, 0);

    // Halt, then a mispredict on the second drain cycle returns to RUN
    step(0, "hlt_a",     0, OP_HLT,   1, 0, 0, C_ZERO,  F_RUN,  1, 0);
    step(0, "drn_a1",    0, OP_NOP,   0, 0, 0, C_ZERO,  F_DRN,  1, 0);
    step(0, "drn_a2mis", 0, OP_NOP,   0, 0, 1, C_ZERO,  F_MIS,  1, 0);
    step(0, "resume",    0, OP_LW,    1, 0, 0, C_LW,    F_RUN,  1, 0);

    // Full drain of STAGES-1 cycles into DONE
    step(0, "hlt_b",     0, OP_HLT,   1, 0, 0, C_ZERO,  F_RUN,  1, 0);
    step(0, "drn_b1",    0, OP_NOP,   0, 0, 0, C_ZERO,  F_DRN,  1, 0);
    step(0, "drn_b2",    1, OP_NOP,   0, 0, 0, C_ZERO,  F_DRN,  1, 0);
    step(0, "drn_b3",    0, OP_NOP,   0, 0, 0, C_ZERO,  F_DRN,  1, 0);
    step(0, "drn_b4",    0, OP_NOP,   0, 0, 0, C_ZERO,  F_DRN,  1, 0);
    step(0, "done1",     0, OP_LW,    1, 0, 0, C_ZERO,  F_DONE, 0, 0);
    step(0, "done2",     0, OP_NOP,   0, 1, 1, C_ZERO,  F_DONE, 0, 0);
    step(0, "restart",   1, OP_NOP,   0, 0, 0, C_ZERO,  F_DONE, 0, 1);
    step(0, "rerun",     0, OP_NOP,   1, 0, 0, C_ZERO,  F_RUN,  1, 0);

    // Reset in the middle of a drain
    step(0, "hlt_c",     0, OP_HLT,   1, 0, 0, C_ZERO,  F_RUN,  1, 0);
    step(0, "drn_c1",    0, OP_NOP,   0, 0, 0, C_ZERO,  F_DRN,  1, 0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    e = '0; sb.push_back(e); compare(0, "rst_mid_drain");
    exp_cnt[0] = 0;
    exp_cnt[1] = 0;
    @(negedge clk);
    rst = 1'b0;
    step(0, "post_rst",  0, OP_LW,    1, 0, 0, C_ZERO,  F_ZERO, 0, 0);

    // Narrow counter saturates at 3
    step(1, "sat_start", 1, OP_NOP,   0, 0, 0, C_ZERO,  F_ZERO, 0, 1);
    for (int i = 0; i < 6; i++)
      step(1, $sformatf("sat%0d", i), 0, OP_NOP, 1, 0, 0, C_ZERO, F_RUN, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
